// File: rtl/mc_pkg.sv
// mc_pkg: shared states, opcodes and ALU codes for mc_controller (state S_BNE exists only with MC_CTRL_BNE_EN)
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
`ifdef MC_CTRL_BNE_EN
    , S_BNE   = 4'd12
`endif
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOP = 3'b011;
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;
endpackage

// File: rtl/mc_controller_alu_dec.sv
// alu_dec: maps aluop and funct to the 3-bit ALU control code
module alu_dec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);
  logic [2:0] funct_code;
  always_comb begin
    funct_code = funct == F_ADD ? ALU_ADD :
                 funct == F_SUB ? ALU_SUB :
                 funct == F_AND ? ALU_AND :
                 funct == F_OR  ? ALU_OR  :
                 funct == F_SLT ? ALU_SLT : ALU_NOP;
    alu_control = aluop == AOP_ADD   ? ALU_ADD :
                  aluop == AOP_SUB   ? ALU_SUB :
                  aluop == AOP_FUNCT ? funct_code : ALU_NOP;
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM and datapath control decode
// Define MC_CTRL_BNE_EN to add the bne instruction (state 12).
module mc_controller
  import mc_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic [3:0] state_o
);
  state_t state_q, state_d, st;
  logic pc_write, branch, ir_write_s, mem_write_s, reg_write_s;
  logic [1:0] aluop;
`ifdef MC_CTRL_BNE_EN
  logic bne;
`endif
  always_ff @(posedge clk)
    state_q <= rst_n ? state_d : state_t'(RESET_STATE);
  // Decode from the reset state while rst_n is low so outputs show FETCH values.
  always_comb begin
    st = rst_n ? state_q : state_t'(RESET_STATE);
    state_d = S_FETCH;
    pc_write = 1'b0;
    branch = 1'b0;
`ifdef MC_CTRL_BNE_EN
    bne = 1'b0;
`endif
    iord = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write_s = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_src = 2'b00;
    aluop = AOP_ADD;
    case (st)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_write = 1'b1;
        alu_src_b = 2'b01;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BNE;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d = op == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write_s = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        aluop = AOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop = AOP_SUB;
        pc_src = 2'b01;
        branch = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: reg_write_s = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_write = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNE: begin
        alu_src_a = 1'b1;
        aluop = AOP_SUB;
        pc_src = 2'b01;
        bne = 1'b1;
      end
`endif
      default: ;
    endcase
  end
`ifdef MC_CTRL_BNE_EN
  assign pc_en = rst_n & (pc_write | (branch & zero) | (bne & ~zero));
`else
  assign pc_en = rst_n & (pc_write | (branch & zero));
`endif
  assign ir_write = rst_n & ir_write_s;
  assign mem_write = rst_n & mem_write_s;
  assign reg_write = rst_n & reg_write_s;
  assign state_o = st;
  alu_dec u_alu_dec (
    .aluop(aluop),
    .funct(funct),
    .alu_control(alu_control)
  );
endmodule
